// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a common-anode bank of seven-segment digits
// sharing one segment bus. One digit is lit per refresh slot. Input data is
// captured into shadow registers only at the frame wrap, so a frame never
// tears. Adds leading-zero blanking, per-digit blinking and optional hex
// glyphs. SEG/DP/AN are registered and lag DIGIT_IDX by one cycle.
//
// Inputs are level signals; there is no valid/ready handshake. Input data is
// sampled only on the frame-wrap tick, and the value present on that cycle
// is the one captured.
module seg7_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLINK_DIV     = 25000000,
  parameter int HEX_EN        = 0,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ENABLE,
  input  logic [4*NUM_DIGITS-1:0]       BCD,
  input  logic [NUM_DIGITS-1:0]         DP_IN,
  input  logic                          BLANK_LZ,
  input  logic [NUM_DIGITS-1:0]         BLINK_MASK,
  output logic [6:0]                    SEG,
  output logic                          DP,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [$clog2(NUM_DIGITS)-1:0] DIGIT_IDX
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int BL_W  = $clog2(BLINK_DIV);

  localparam logic [RC_W-1:0]       RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [BL_W-1:0]       BL_LAST  = BL_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF  = 7'b1111111;

  // Scan state
  logic [RC_W-1:0]         r_rc;
  logic [IDX_W-1:0]        r_idx;
  // Blink state
  logic [BL_W-1:0]         r_bl_cnt;
  logic                    r_bl_phase;
  // Frame-coherent copies of the inputs
  logic [4*NUM_DIGITS-1:0] r_sh_bcd;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_mask;
  // Registered pin drivers
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tick;
  logic                    w_frame_wrap;
  logic [3:0]              w_code;
  logic                    w_dp_req;
  logic                    w_mask_bit;
  logic                    w_upper_nz;
  logic                    w_lz_blank;
  logic                    w_blink_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_glyph;

  // Active-low glyph lookup; codes above 9 are blank unless hex is enabled.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = (HEX_EN != 0) ? 7'b0001000 : SEG_OFF;
      4'hB:    g = (HEX_EN != 0) ? 7'b1100000 : SEG_OFF;
      4'hC:    g = (HEX_EN != 0) ? 7'b0110001 : SEG_OFF;
      4'hD:    g = (HEX_EN != 0) ? 7'b1000010 : SEG_OFF;
      4'hE:    g = (HEX_EN != 0) ? 7'b0110000 : SEG_OFF;
      default: g = (HEX_EN != 0) ? 7'b0111000 : SEG_OFF;
    endcase
    return g;
  endfunction

  assign w_tick       = ENABLE & (r_rc == RC_LAST);
  assign w_frame_wrap = w_tick & (r_idx == IDX_LAST);

  // Select the current digit's shadow data and check whether any digit at or
  // above the current position is nonzero (leading-zero detection).
  always_comb begin
    w_code     = 4'h0;
    w_dp_req   = 1'b0;
    w_mask_bit = 1'b0;
    w_upper_nz = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_code      = r_sh_bcd[4*i +: 4];
        w_dp_req    = r_sh_dp[i];
        w_mask_bit  = r_sh_mask[i];
        w_onehot[i] = 1'b1;
      end
      if ((IDX_W'(i) >= r_idx) && (r_sh_bcd[4*i +: 4] != 4'h0)) begin
        w_upper_nz = 1'b1;
      end
    end
  end

  assign w_lz_blank    = BLANK_LZ & (r_idx != '0) & ~w_upper_nz;
  assign w_blink_blank = r_bl_phase & w_mask_bit;
  assign w_glyph       = decode(w_code);

  // Refresh counter and digit index advance only while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rc  <= '0;
      r_idx <= '0;
    end else if (ENABLE) begin
      if (r_rc == RC_LAST) begin
        r_rc  <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_rc <= r_rc + 1'b1;
      end
    end
  end

  // Blink timebase runs regardless of ENABLE; phase flips at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bl_cnt   <= '0;
      r_bl_phase <= 1'b0;
    end else if (r_bl_cnt == BL_LAST) begin
      r_bl_cnt   <= '0;
      r_bl_phase <= ~r_bl_phase;
    end else begin
      r_bl_cnt <= r_bl_cnt + 1'b1;
    end
  end

  // Capture the inputs once per frame, on the wrap tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_bcd  <= '0;
      r_sh_dp   <= '0;
      r_sh_mask <= '0;
    end else if (w_frame_wrap) begin
      r_sh_bcd  <= BCD;
      r_sh_dp   <= DP_IN;
      r_sh_mask <= BLINK_MASK;
    end
  end

  // Register the pin drivers from the current index and shadow state.
  always_ff @(posedge clk) begin
    if (rst || !ENABLE) begin
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
      r_an  <= AN_OFF;
    end else begin
      r_an <= (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      if (w_blink_blank) begin
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end else begin
        r_seg <= w_lz_blank ? SEG_OFF : w_glyph;
        r_dp  <= ~w_dp_req;
      end
    end
  end

  assign SEG       = r_seg;
  assign DP        = r_dp;
  assign AN        = r_an;
  assign DIGIT_IDX = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (decimal and hex glyph sets)
// share stimulus; a cycle-level reference model derived from elapsed-cycle
// arithmetic predicts the registered outputs.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BD = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          enable   = 1'b0;
  logic [15:0]   bcd      = '0;
  logic [3:0]    dp_in    = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    mask     = '0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic [1:0] idx0, idx1;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_DIV(BD),
                     .HEX_EN(0), .AN_ACTIVE_LOW(1)) dut_dec (
    .clk(clk), .rst(rst), .ENABLE(enable), .BCD(bcd), .DP_IN(dp_in),
    .BLANK_LZ(blank_lz), .BLINK_MASK(mask),
    .SEG(seg0), .DP(dp0), .AN(an0), .DIGIT_IDX(idx0));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_DIV(BD),
                     .HEX_EN(1), .AN_ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .rst(rst), .ENABLE(enable), .BCD(bcd), .DP_IN(dp_in),
    .BLANK_LZ(blank_lz), .BLINK_MASK(mask),
    .SEG(seg1), .DP(dp1), .AN(an1), .DIGIT_IDX(idx1));

  int total = 0;
  int bad   = 0;

  // Reference model: index from count of enabled cycles, blink phase from
  // count of cycles out of reset, shadow captured at each frame boundary.
  int unsigned m_en_cnt = 0;
  int unsigned m_bl_cnt = 0;
  logic [15:0] m_sh_bcd  = '0;
  logic [3:0]  m_sh_dp   = '0;
  logic [3:0]  m_sh_mask = '0;
  logic [6:0]  e_seg0 = 7'h7F, e_seg1 = 7'h7F;
  logic        e_dp = 1'b1;
  logic [3:0]  e_an = 4'hF;
  logic [1:0]  e_idx = '0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] c, input bit hex);
    case (c)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      10: return hex ? 7'b0001000 : 7'b1111111;
      11: return hex ? 7'b1100000 : 7'b1111111;
      12: return hex ? 7'b0110001 : 7'b1111111;
      13: return hex ? 7'b1000010 : 7'b1111111;
      14: return hex ? 7'b0110000 : 7'b1111111;
      default: return hex ? 7'b0111000 : 7'b1111111;
    endcase
  endfunction

  always @(posedge clk) begin
    int          d;
    bit          phase, blink_off, lz_off;
    logic [15:0] above;
    if (rst) begin
      m_en_cnt = 0; m_bl_cnt = 0;
      m_sh_bcd = '0; m_sh_dp = '0; m_sh_mask = '0;
      e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      d     = (m_en_cnt / RD) % N;
      phase = ((m_bl_cnt / BD) % 2) == 1;
      if (enable) begin
        above     = m_sh_bcd >> (4 * d);
        blink_off = phase && m_sh_mask[d];
        lz_off    = blank_lz && (d != 0) && (above == 16'h0);
        e_seg0 = (blink_off || lz_off) ? 7'h7F : ref_glyph(above[3:0], 1'b0);
        e_seg1 = (blink_off || lz_off) ? 7'h7F : ref_glyph(above[3:0], 1'b1);
        e_dp   = blink_off ? 1'b1 : ~m_sh_dp[d];
        e_an   = ~(4'b0001 << d);
        if ((m_en_cnt % (N * RD)) == (N * RD - 1)) begin
          m_sh_bcd = bcd; m_sh_dp = dp_in; m_sh_mask = mask;
        end
        m_en_cnt++;
      end else begin
        e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end
      m_bl_cnt++;
    end
    e_idx = 2'((m_en_cnt / RD) % N);
  end

  // Scoreboard comparisons against the model
  task automatic check_all(input string tag);
    total++;
    assert (seg0 === e_seg0) else begin
      bad++; $error("FAIL %s seg_dec got=%b exp=%b", tag, seg0, e_seg0);
    end
    total++;
    assert (seg1 === e_seg1) else begin
      bad++; $error("FAIL %s seg_hex got=%b exp=%b", tag, seg1, e_seg1);
    end
    total++;
    assert (dp0 === e_dp && dp1 === e_dp) else begin
      bad++; $error("FAIL %s dp got=%b/%b exp=%b", tag, dp0, dp1, e_dp);
    end
    total++;
    assert (an0 === e_an && an1 === e_an) else begin
      bad++; $error("FAIL %s an got=%b/%b exp=%b", tag, an0, an1, e_an);
    end
    total++;
    assert (idx0 === e_idx && idx1 === e_idx) else begin
      bad++; $error("FAIL %s idx got=%0d/%0d exp=%0d", tag, idx0, idx1, e_idx);
    end
  endtask

  // Directed constant check for values stated outright by the behaviour
  task automatic check_const(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: advance n cycles, checking at each falling edge
  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
    end
  endtask

  initial begin
    // Reset state
    step(3, "reset");
    check_const("reset_seg", {9'd0, seg0}, 16'h007F);
    check_const("reset_an",  {12'd0, an0}, 16'h000F);
    check_const("reset_dp",  {15'd0, dp0}, 16'h0001);
    check_const("reset_idx", {14'd0, idx0}, 16'h0000);

    // Scan sequence from reset release
    rst = 1'b0; enable = 1'b1;
    step(1, "scan_first");
    check_const("first_an", {12'd0, an0}, 16'h000E);
    step(15, "scan");
    check_const("wrap_idx", {14'd0, idx0}, 16'h0000);
    check_const("wrap_an",  {12'd0, an0}, 16'h0007);

    // Plain decimal digits with one decimal point
    bcd = 16'h1234; dp_in = 4'b0100; blank_lz = 1'b0;
    step(2 * N * RD, "bcd1234");
    // Leading-zero blanking
    bcd = 16'h0070; dp_in = 4'b0000; blank_lz = 1'b1;
    step(2 * N * RD, "lz0070");
    bcd = 16'h0000;
    step(2 * N * RD, "lz0000");
    // Hex codes
    bcd = 16'h00AF; blank_lz = 1'b0;
    step(2 * N * RD, "hex00af");
    // Blink digit 0
    bcd = 16'h0008; mask = 4'b0001;
    step(5 * BD, "blink");
    mask = 4'b0000;
    // Mid-frame data change: current frame must keep the old shadow
    bcd = 16'h1111;
    step(2 * N * RD + 6, "tear1");
    bcd = 16'h2222;
    step(2 * N * RD, "tear2");
    // Enable dropped mid-frame, then resumed
    step(5, "pre_dis");
    enable = 1'b0;
    step(1, "dis_first");
    check_const("dis_an", {12'd0, an0}, 16'h000F);
    step(6, "disabled");
    enable = 1'b1;
    step(2 * N * RD, "resume");
    // Reset pulse mid-frame
    step(7, "pre_rst");
    rst = 1'b1;
    step(1, "rst_pulse");
    check_const("rst_pulse_idx", {14'd0, idx0}, 16'h0000);
    check_const("rst_pulse_seg", {9'd0, seg0}, 16'h007F);
    rst = 1'b0;
    step(N * RD, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bcd = 16'($urandom);
          1: bcd = 16'($urandom) & 16'h00FF;
          2: bcd = 16'($urandom) & 16'h000F;
          default: bcd = 16'h0000;
        endcase
        dp_in    = 4'($urandom);
        mask     = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      enable = ($urandom_range(0, 15) != 0);
      rst    = ($urandom_range(0, 599) == 0);
      step(1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a common-anode bank of NUM_DIGITS seven-segment digits that share one segment bus.
- Takes packed BCD, or optionally hex, digit data plus per-digit decimal points, and scans one digit per refresh slot.
- Adds leading-zero blanking, per-digit blinking and frame-coherent input capture, none of which the plain combinational BCD decoder has.
- Sits between the counter/datapath logic and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).
- HEX_EN, 0, 1 = codes 10..15 show A,b,C,d,E,F; 0 = codes >9 are blanked.
- AN_ACTIVE_LOW, 1, 1 = selected anode driven 0; 0 = selected anode driven 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ENABLE  in  1  1 = scan runs; 0 = display dark, counters held.
- BCD  in  4*NUM_DIGITS  packed digit codes; bits [4i+3:4i] = digit i; digit 0 is rightmost/least significant.
- DP_IN  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- BLANK_LZ  in  1  1 = enable leading-zero blanking.
- BLINK_MASK  in  NUM_DIGITS  1 = digit blinks.
- SEG  out  7  active-low segments; bit6 = a, bit5 = b … bit0 = g.
- DP  out  1  active-low decimal point.
- AN  out  NUM_DIGITS  digit enables, polarity set by AN_ACTIVE_LOW.
- DIGIT_IDX  out  clog2(NUM_DIGITS)  index of the digit currently being driven (debug/test).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: refresh counter 0, DIGIT_IDX 0, blink counter 0, blink phase 0, shadow digit/DP/mask registers 0, SEG 7'b1111111, DP 1, AN all inactive.
- Refresh counter rc:
  - Counts 0..REFRESH_DIV-1 while ENABLE=1.
  - Tick = ENABLE & (rc==REFRESH_DIV-1).
  - On tick: rc <= 0 and DIGIT_IDX <= DIGIT_IDX+1, wrapping NUM_DIGITS-1 -> 0.
  - Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- Shadow capture:
  - On a tick with DIGIT_IDX==NUM_DIGITS-1 (the frame wrap), BCD, DP_IN and BLINK_MASK are copied into the shadow registers.
  - Decoding uses only the shadow registers, so a display frame never tears.
  - The first frame after reset therefore shows shadow = 0.
- Blink:
  - Blink counter runs 0..BLINK_DIV-1 regardless of ENABLE and toggles the blink phase at terminal count.
  - While phase=1, every digit with shadow mask bit set is blanked: SEG=1111111, DP=1.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i is blanked if shadow digits i..NUM_DIGITS-1 are all 0 and i != 0.
  - Digit 0 is never blanked by this rule.
  - A blanked digit's DP is still driven from shadow DP_IN.
- Decode table, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - HEX_EN=1: A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
  - HEX_EN=0: codes 10..15 = 1111111.
- Output registers:
  - SEG, DP and AN are registered, computed each cycle from the current DIGIT_IDX and shadow state.
  - They lag DIGIT_IDX by exactly 1 cycle.
  - Exactly one anode is active when ENABLE=1 (after that 1-cycle lag).
- ENABLE=0: rc and DIGIT_IDX hold; on the next cycle AN goes all inactive and SEG = 1111111, DP = 1.
- ENABLE re-asserted: scanning resumes from the held DIGIT_IDX and rc with no skipped digit.
- Reset asserted mid-scan: all state returns to reset values on that edge, including the shadow registers.
- Simultaneous frame-wrap tick and input change: the value present on that cycle is the one captured.
- Blink toggle mid-digit: takes effect on the output registers 1 cycle later.

Test Plan:
- Params NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=64. Release rst with ENABLE=1 -> AN sequence 1110,1101,1011,0111 each lasting 4 cycles, first AN active 1 cycle after the first post-reset edge; DIGIT_IDX wraps to 0 after 16 cycles.
- BCD=16'h1234, BLANK_LZ=0, DP_IN=4'b0100. After the first frame wrap, the next frame shows SEG 1001100, 0000110, 0010010, 1001111 for digits 0..3; DP=0 only while AN=1011.
- BCD=16'h0070, BLANK_LZ=1 -> digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001. BCD=0, BLANK_LZ=1 -> digit 0 shows 0000001, the others are blank.
- BCD=16'h00AF: with HEX_EN=0, digits 0 and 1 show 1111111; with HEX_EN=1, digit 0 shows 0111000 and digit 1 shows 0001000.
- BLINK_MASK=4'b0001, BCD=16'h0008 -> digit 0 alternates between 0000000 for 64 cycles and 1111111 for 64 cycles; digits 1..3 are unaffected.
- Change BCD mid-frame from 16'h1111 to 16'h2222 -> the rest of the current frame still shows 1; the next frame shows 2. Drop ENABLE mid-frame -> AN all inactive next cycle and DIGIT_IDX frozen. Pulse rst mid-frame -> all outputs at reset values next cycle.
